// File: rtl/serial_chunk_adder_pkg.sv
// Shared types and elaboration-time helpers for the chunk-serial adder/subtractor.
// Imported by serial_chunk_adder and chunk_adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 2;
  localparam int MIN_CHUNK     = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk must be non-zero, no wider than the operand, and divide it evenly.
  function automatic bit params_ok(input int width, input int chunk);
    return (chunk >= MIN_CHUNK) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

  function automatic int calc_cnt_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/serial_chunk_adder_if.sv
// Operand/result handshake bundle for serial_chunk_adder.
// master = producer/consumer side, slave = the adder.
interface serial_chunk_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/serial_chunk_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB
// so the caller can form signed overflow.
module chunk_adder
  import serial_adder_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_c_msb
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout  = w_c[CHUNK];
  assign o_c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: CHUNK bits per clock, LS chunk first, IDLE/BUSY/DONE handshake.
// Optional subtract support is built when SERIAL_ADDER_SUB_EN is defined.
module serial_chunk_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_chunk_adder_if.slave   bus
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = calc_cnt_w(NCHUNK);

  if (!params_ok(WIDTH, CHUNK)) begin : g_param_err
    $error("serial_chunk_adder: CHUNK=%0d must be in 1..WIDTH and divide WIDTH=%0d",
           CHUNK, WIDTH);
  end

  state_e             r_state;
  state_e             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_b_eff;
  logic [CHUNK-1:0]   w_chunk_sum;
  logic               w_chunk_cout;
  logic               w_chunk_c_msb;
  logic [WIDTH-1:0]   w_sum_shift;
  logic [WIDTH-1:0]   w_a_shift;
  logic [WIDTH-1:0]   w_b_shift;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_eff = bus.sub ? ~bus.b : bus.b;
`else
  assign w_b_eff = bus.b;
`endif

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_cnt == CNT_W'(NCHUNK - 1));

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .i_a     (r_a[CHUNK-1:0]),
    .i_b     (r_b[CHUNK-1:0]),
    .i_cin   (r_carry),
    .o_sum   (w_chunk_sum),
    .o_cout  (w_chunk_cout),
    .o_c_msb (w_chunk_c_msb)
  );

  // Operands shift right so the active chunk always sits in the low bits;
  // the sum fills from the top and is fully aligned after NCHUNK shifts.
  if (NCHUNK == 1) begin : g_single
    assign w_sum_shift = w_chunk_sum;
    assign w_a_shift   = '0;
    assign w_b_shift   = '0;
  end else begin : g_multi
    assign w_sum_shift = {w_chunk_sum, r_sum[WIDTH-1:CHUNK]};
    assign w_a_shift   = {{CHUNK{1'b0}}, r_a[WIDTH-1:CHUNK]};
    assign w_b_shift   = {{CHUNK{1'b0}}, r_b[WIDTH-1:CHUNK]};
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_next = BUSY;
      end
      BUSY: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: the result registers are visible outputs with defined reset values,
  // so the whole datapath is reset rather than only the control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= bus.a;
        r_b     <= w_b_eff;
        r_carry <= bus.cin;
        r_cnt   <= '0;
      end else if (r_state == BUSY) begin
        r_a     <= w_a_shift;
        r_b     <= w_b_shift;
        r_carry <= w_chunk_cout;
        r_cnt   <= r_cnt + CNT_W'(1);
        r_sum   <= w_sum_shift;
        // Only the final chunk's values survive into DONE.
        r_cout  <= w_chunk_cout;
        r_ovf   <= w_chunk_cout ^ w_chunk_c_msb;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule
